// File: rtl/audiodac_sample_reader.sv
// Read-side master of the 16b sample interface: strobes the source once per OSR clocks and
// streams samples to the modulator. Define AUDIODAC_READER_INTERP_EN for linear interpolation.
module audiodac_sample_reader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [1:0]        osr_i,
    output logic              data_rd_o,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              smp_tick_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       rd_q, rd_d;
    logic       capture;

    function automatic logic [7:0] osr_last(input logic [1:0] sel);
        logic [7:0] v;
        case (sel)
            2'd0:    v = 8'd31;
            2'd1:    v = 8'd63;
            2'd2:    v = 8'd127;
            default: v = 8'd255;
        endcase
        return v;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == 8'd0) begin
            rd_d  = 1'b1;
            cnt_d = osr_last(osr_i);
        end else begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // A strobe that coincides with en_i low is discarded: the clear takes priority.
    assign capture    = rd_q & en_i;
    assign data_rd_o  = rd_q;
    assign smp_tick_o = rd_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            rd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
        end
    end

`ifdef AUDIODAC_READER_INTERP_EN
    localparam int unsigned AccW = DATA_W + 1 + FRAC_W;

    logic        [1:0]        osr_q, osr_d;
    logic        [DATA_W-1:0] prev_q, prev_d;
    logic signed [AccW-1:0]   acc_q, acc_d;
    logic signed [AccW-1:0]   step_q, step_d;
    logic signed [DATA_W:0]   delta;
    logic        [4:0]        shamt;

    always_comb begin
        delta  = $signed({data_i[DATA_W-1], data_i}) - $signed({prev_q[DATA_W-1], prev_q});
        // step = delta * 2^FRAC_W / OSR, exact because OSR is a power of two <= 2^FRAC_W
        shamt  = 5'(FRAC_W - 5) - {3'b000, osr_q};
        osr_d  = rd_d ? osr_i : osr_q;
        prev_d = prev_q;
        acc_d  = acc_q + step_q;
        step_d = step_q;
        if (!en_i) begin
            prev_d = '0;
            acc_d  = '0;
            step_d = '0;
        end else if (capture) begin
            prev_d = data_i;
            acc_d  = {prev_q[DATA_W-1], prev_q, {FRAC_W{1'b0}}};
            step_d = {{(AccW-DATA_W-1){delta[DATA_W]}}, delta} <<< shamt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            osr_q  <= '0;
            prev_q <= '0;
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            osr_q  <= osr_d;
            prev_q <= prev_d;
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

    assign data_o = acc_q[FRAC_W +: DATA_W];
`else
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (!en_i) begin
            data_d = '0;
        end else if (capture) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
`endif

endmodule

// File: tb/tb_audiodac_sample_reader.sv
// Randomized bench for audiodac_sample_reader against a timestamp/arithmetic reference model.
module tb_audiodac_sample_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  osr;
    logic [15:0] din;
    logic        rd;
    logic        tick_o;
    logic [15:0] dout;

    always #5 clk = ~clk;

    audiodac_sample_reader dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .osr_i      (osr),
        .data_rd_o  (rd),
        .data_i     (din),
        .data_o     (dout),
        .smp_tick_o (tick_o)
    );

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    // Reference model: strobe times from timestamps, data_o from the ramp formula.
    bit m_rd;
    bit m_idle;
    int m_cyc;
    int m_next;
    int m_period;
    int m_p;
    int m_a;
    int m_b;
    int m_k;
    int m_zoh;
    int src_q[$];

    function automatic int exp_dout();
`ifdef AUDIODAC_READER_INTERP_EN
        return (m_a * m_p + m_k * (m_b - m_a)) >>> $clog2(m_p);
`else
        return m_zoh;
`endif
    endfunction

    task automatic model_reset();
        m_rd     = 1'b0;
        m_idle   = 1'b1;
        m_next   = 0;
        m_period = 32;
        m_p      = 32;
        m_a      = 0;
        m_b      = 0;
        m_k      = 0;
        m_zoh    = 0;
    endtask

    task automatic model_edge();
        bit nrd;
        nrd = 1'b0;
        if (!en) begin
            m_idle = 1'b1;
            m_a    = 0;
            m_b    = 0;
            m_k    = 0;
            m_zoh  = 0;
        end else begin
            if (m_rd) begin
                m_a   = m_b;
                m_b   = $signed(din);
                m_k   = 0;
                m_p   = m_period;
                m_zoh = $signed(din);
            end else begin
                m_k++;
            end
            if (m_idle || (m_cyc + 1 == m_next)) begin
                nrd      = 1'b1;
                m_period = 32 << osr;
                m_next   = m_cyc + 1 + m_period;
                m_idle   = 1'b0;
            end
        end
        m_cyc++;
        m_rd = nrd;
    endtask

    // Called at a negedge; inputs for this cycle are already set except data_i.
    task automatic tick();
        if (m_rd && src_q.size() > 0) din = 16'(src_q.pop_front());
        else                          din = 16'($urandom);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("rd", rd, m_rd);
        check("tick", tick_o, m_rd);
        check("dout", $signed(dout), exp_dout());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rd", rd, 0);
        check("rst_dout", $signed(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int last;
        rst_n = 1'b1;
        en    = 1'b0;
        osr   = 2'd0;
        din   = '0;
        m_cyc = 0;
        model_reset();
        #2;

        phase = "reset";
        do_reset();
        repeat (50) tick();

        phase = "en32";
        en = 1'b1;
        tick();
        check("first_strobe", rd, 1);
        repeat (31) tick();
        tick();
        check("strobe32", rd, 1);
        repeat (60) tick();

        phase = "osr_sweep";
        for (int o = 1; o < 4; o++) begin
            repeat ($urandom_range(1, 20)) tick();
            osr = 2'(o);
            repeat (2 * (32 << o) + 10) tick();
        end

        phase = "ramp";
        en = 1'b0;
        tick();
        src_q = {0, 3200, 3200};
        osr = 2'd0;
        en  = 1'b1;
        tick();
        check("s1", rd, 1);
        repeat (32) tick();
        check("s2", rd, 1);
        tick();
`ifdef AUDIODAC_READER_INTERP_EN
        check("k0", $signed(dout), 0);
`else
        check("k0", $signed(dout), 3200);
`endif
        for (int j = 1; j < 32; j++) begin
            tick();
`ifdef AUDIODAC_READER_INTERP_EN
            check("kj", $signed(dout), 100 * j);
`else
            check("kj", $signed(dout), 3200);
`endif
        end
        check("s3", rd, 1);
        tick();
        check("final", $signed(dout), 3200);

        phase = "extreme";
        en = 1'b0;
        tick();
        src_q = {-32768, 32767};
        osr = 2'd3;
        en  = 1'b1;
        tick();
        repeat (256) tick();
        check("s2", rd, 1);
        last = -40000;
        for (int j = 0; j < 256; j++) begin
            tick();
            check("mono", int'($signed(dout) >= last), 1);
            last = $signed(dout);
        end
`ifdef AUDIODAC_READER_INTERP_EN
        check("last", $signed(dout), 32511);
`else
        check("last", $signed(dout), 32767);
`endif
        check("s3", rd, 1);

        phase = "abort";
        osr = 2'd0;
        tick();
        n = 0;
        while (!m_rd && n < 600) begin
            tick();
            n++;
        end
        check("found_strobe", rd, 1);
        en = 1'b0;
        tick();
        check("cleared", $signed(dout), 0);
        check("no_rd", rd, 0);
        en = 1'b1;
        tick();
        check("restart", rd, 1);
        repeat (100) tick();

        phase = "rst_mid";
        repeat (45) tick();
        do_reset();
        tick();
        check("restart", rd, 1);
        repeat (80) tick();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 99) < 2) osr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) < 2) do_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
